uart_hex_link: RTL

Full-duplex 8N1 UART endpoint that exchanges W-bit words as ASCII hexadecimal text, for console debug on the FPGA board. The TX side takes a word through a valid/ready handshake and sends its hex digits MSB-nibble-first, optionally followed by CR LF. The RX side assembles typed hex digits into a word and commits it on CR. It replaces the fixed 32-bit, fixed-baud TX/RX glue in the top-level interface and sits between the CPU/debug register file and the board UART pins.

---
 rtl/uart_hex_pkg.sv | 24 ++
 rtl/uart_byte_rx.sv | 91 +++++++++
 rtl/uart_hex_link.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_hex_pkg.sv
// rtl/uart_hex_pkg.sv - shared constants, state types and hex/ASCII helpers
package uart_hex_pkg;

  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_SP = 8'h20;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Nibble to uppercase ASCII hex digit
  function automatic logic [7:0] hex2asc(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // ASCII to {valid, nibble}; accepts 0-9, A-F, a-f
  function automatic logic [4:0] asc2hex(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    return 5'b0;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 byte receiver with synchronizer and framing check
module uart_byte_rx
  import uart_hex_pkg::*;
#(
  parameter int DIV = 10417
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam int CW = $clog2(DIV);

  logic          sync1_q, sync2_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;

  // Two-flop synchronizer for the asynchronous serial line, idles high
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  // Next state: half-bit start qualification, then one sample per bit period
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_d     = bit_q;
    sh_d      = sh_q;
    byte_vld  = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CW'(DIV / 2 - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d     = '0;
          state_d   = RX_IDLE;
          byte_vld  = sync2_q;
          frame_err = !sync2_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Receiver state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  assign byte_data = sh_q;

endmodule

// File: rtl/uart_hex_link.sv
// rtl/uart_hex_link.sv - UART endpoint exchanging words as ASCII hex text
module uart_hex_link
  import uart_hex_pkg::*;
#(
  parameter int W       = 32,
  parameter int DIV     = 10417,
  parameter bit NEWLINE = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] tx_word,
  input  logic         tx_vld,
  output logic         tx_rdy,
  output logic         txd,
  input  logic         rxd,
  output logic [W-1:0] rx_word,
  output logic         rx_vld,
  output logic         rx_err
);

  localparam int ND  = W / 4;
  localparam int NCH = ND + (NEWLINE ? 2 : 0);
  localparam int CW  = $clog2(DIV);
  localparam int IW  = $clog2(NCH + 1);
  localparam int DW  = $clog2(ND + 1);

  // ---------------- TX ----------------
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [7:0]    char_q, char_d;
  logic [2:0]    bit_q, bit_d;
  logic [IW-1:0] ch_idx_q, ch_idx_d;
  logic          txd_q, txd_d;
  logic          tx_rdy_q, tx_rdy_d;
  logic [7:0]    next_char;

  // TX next state: load next character at every stop-bit end until all are sent
  always_comb begin
    tx_state_d = tx_state_q;
    baud_d     = baud_q + CW'(1);
    shift_d    = shift_q;
    char_d     = char_q;
    bit_d      = bit_q;
    ch_idx_d   = ch_idx_q;
    txd_d      = txd_q;
    tx_rdy_d   = tx_rdy_q;
    if (ch_idx_q < IW'(ND))       next_char = hex2asc(shift_q[W-1 -: 4]);
    else if (ch_idx_q == IW'(ND)) next_char = ASC_CR;
    else                          next_char = ASC_LF;
    case (tx_state_q)
      TX_IDLE: begin
        baud_d = '0;
        if (tx_vld && tx_rdy_q) begin
          shift_d    = tx_word << 4;
          char_d     = hex2asc(tx_word[W-1 -: 4]);
          ch_idx_d   = IW'(1);
          txd_d      = 1'b0;
          tx_rdy_d   = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_q == CW'(DIV - 1)) begin
          baud_d     = '0;
          txd_d      = char_q[0];
          char_d     = char_q >> 1;
          bit_d      = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (baud_q == CW'(DIV - 1)) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            txd_d  = char_q[0];
            char_d = char_q >> 1;
            bit_d  = bit_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (baud_q == CW'(DIV - 1)) begin
          baud_d = '0;
          if (ch_idx_q == IW'(NCH)) begin
            tx_rdy_d   = 1'b1;
            tx_state_d = TX_IDLE;
          end else begin
            char_d     = next_char;
            shift_d    = shift_q << 4;
            ch_idx_d   = ch_idx_q + IW'(1);
            txd_d      = 1'b0;
            tx_state_d = TX_START;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX FSM and its registered line/ready outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= TX_IDLE;
      baud_q     <= '0;
      shift_q    <= '0;
      char_q     <= '0;
      bit_q      <= '0;
      ch_idx_q   <= '0;
      txd_q      <= 1'b1;
      tx_rdy_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      baud_q     <= baud_d;
      shift_q    <= shift_d;
      char_q     <= char_d;
      bit_q      <= bit_d;
      ch_idx_q   <= ch_idx_d;
      txd_q      <= txd_d;
      tx_rdy_q   <= tx_rdy_d;
    end
  end

  assign txd    = txd_q;
  assign tx_rdy = tx_rdy_q;

  // ---------------- RX ----------------
  logic [7:0]    rx_byte;
  logic          byte_vld, frame_err;
  logic [W-1:0]  acc_q, acc_d, rx_word_q, rx_word_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          rx_vld_q, rx_vld_d, rx_err_q, rx_err_d;
  logic [4:0]    hx;

  uart_byte_rx #(.DIV(DIV)) u_byte_rx (
    .clk       (clk),
    .rstn      (rstn),
    .rxd       (rxd),
    .byte_data (rx_byte),
    .byte_vld  (byte_vld),
    .frame_err (frame_err)
  );

  // Hex assembly: digits shift in, CR commits, LF/space ignored, rest is an error
  always_comb begin
    hx        = asc2hex(rx_byte);
    acc_d     = acc_q;
    dcnt_d    = dcnt_q;
    rx_word_d = rx_word_q;
    rx_vld_d  = 1'b0;
    rx_err_d  = 1'b0;
    if (frame_err) begin
      rx_err_d = 1'b1;
      acc_d    = '0;
      dcnt_d   = '0;
    end else if (byte_vld) begin
      if (hx[4]) begin
        acc_d = (acc_q << 4) | W'(hx[3:0]);
        if (dcnt_q != DW'(ND)) dcnt_d = dcnt_q + DW'(1);
      end else if (rx_byte == ASC_CR) begin
        if (dcnt_q != '0) begin
          rx_word_d = acc_q;
          rx_vld_d  = 1'b1;
          acc_d     = '0;
          dcnt_d    = '0;
        end
      end else if (rx_byte != ASC_LF && rx_byte != ASC_SP) begin
        rx_err_d = 1'b1;
        acc_d    = '0;
        dcnt_d   = '0;
      end
    end
  end

  // RX assembly registers and one-cycle result pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q     <= '0;
      dcnt_q    <= '0;
      rx_word_q <= '0;
      rx_vld_q  <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      dcnt_q    <= dcnt_d;
      rx_word_q <= rx_word_d;
      rx_vld_q  <= rx_vld_d;
      rx_err_q  <= rx_err_d;
    end
  end

  assign rx_word = rx_word_q;
  assign rx_vld  = rx_vld_q;
  assign rx_err  = rx_err_q;

endmodule
